seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
//  - Time-multiplexed driver for the 4-digit common-anode seven-segment display.
//  - Takes the three BCD digits from the binary-to-BCD stage (ones, tens, hundreds).
//  - Snapshots them on a load strobe and scans them onto shared cathodes, one anode at a time.
//  - Adds leading-zero blanking, inter-digit dead time (anti-ghosting) and an optional blink.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz/slot, 250 Hz frame); must be >= 2
//  DEAD_CYCLES  500     cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
//  BLINK_DIV    125     completed frames per blink half-period; must be >= 1
// PORTS
//  clk       in   1  system clock
//  reset     in   1  synchronous, active-high reset
//  digit0    in   4  BCD ones digit
//  digit1    in   4  BCD tens digit
//  digit2    in   4  BCD hundreds digit
//  load      in   1  1-cycle strobe: capture digit0..2 into the display snapshot
//  lzb_en    in   1  1 = blank leading zeros (digit2, then digit1); digit0 is never blanked
//  blink_en  in   1  1 = display alternates on/off every BLINK_DIV frames
//  an        out  4  anode enables, active-low; an[i] drives position i (0 = rightmost)
//  seg       out  7  cathodes, active-low, {g,f,e,d,c,b,a}
//  dp        out  1  decimal point, active-low; held 1 (off)
// BEHAVIOUR
//  - Reset:
//    - an=4'b1111, seg=7'b1111111, dp=1.
//    - Snapshot digits=0; refresh counter=0; scan index=0; frame counter=0; blink phase=ON.
//  - Snapshot:
//    - When load=1 at a clk edge, the snapshot takes digit0..2.
//    - Positions not yet driven in the current frame show the new value; a position is never torn mid-slot.
//    - The new value appears at the next slot boundary.
//  - Refresh counter: counts 0..REFRESH_DIV-1 and wraps.
//    - At count REFRESH_DIV-1 the scan index advances 0->1->2->3->0.
//    - The frame counter increments when the index wraps 3->0.
//  - Dead time: while the refresh count is < DEAD_CYCLES, an=4'b1111.
//    - seg already carries the new slot's pattern during dead time.
//  - Slot 3 has no source digit: an[3] is always 1 and seg=7'b1111111.
//    - Slot 3 still consumes a full slot, so duty stays 1/4.
//  - Blanking, evaluated on the snapshot:
//    - pos2 is blank if lzb_en and d2==0.
//    - pos1 is blank if lzb_en and d2==0 and d1==0.
//    - A blank position keeps its anode off.
//  - Decode, via bcd_to_seg:
//    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
//    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//    - 10..15 show a dash, 0111111.
//  - Blink:
//    - The phase toggles when the frame counter reaches BLINK_DIV-1 at a frame wrap; the counter then clears.
//    - If blink_en=1 and phase=OFF, an=4'b1111.
//    - If blink_en=0, the phase is forced to ON and the frame counter is held at 0.
//  - Outputs:
//    - an/seg are registered.
//    - They reflect the scan index and refresh count of the previous cycle (1-cycle latency).
//  - Reset mid-scan: at the next edge, all outputs return to their reset values and all counters restart from 0.
//  - load during reset is ignored.
// STRUCTURE
//  - Shared header seg_consts.vh holds:
//    - the segment patterns (SEG_0..SEG_9, SEG_DASH, SEG_OFF);
//    - AN_OFF=4'b1111.
//  - Sub-module bcd_to_seg: combinational 4-bit to 7-bit active-low decoder, one instance on the muxed digit.
//  - Top contains: snapshot register, refresh/scan/frame counters, blink phase flop, output registers.
// TESTING  (REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_DIV=2)
//  - Reset -> an=1111, seg=1111111, dp=1; load digits 1,2,3 -> pos0 seg=1111001, an=1110 after dead cycle.
//  - Snapshot 7,0,0 with lzb_en=1 -> only an[0] ever goes low; seg=1111000; lzb_en=0 -> pos1/pos2 show 1000000.
//  - Sweep one full frame -> per 4-cycle slot exactly 1 dead cycle (an=1111), then 3 cycles with a single low anode; slot 3 fully dark.
//  - digit1=4'hC -> pos1 shows 0111111; load pulse mid-slot -> current slot unchanged, next slot new value.
//  - blink_en=1 -> 2 frames lit, 2 frames all anodes off, repeating; drop blink_en -> lit next cycle.
//  - Assert reset during slot 2 -> next edge an=1111; scan resumes at pos0 with count 0.

Source files
------------

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Holds the active-low segment patterns ({g,f,e,d,c,b,a}), the all-anodes-off
// value, the blink phase enum, the packed three-digit snapshot type and a
// helper that decides whether a scan position is a blanked leading zero.
package seven_seg_scan_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } blink_phase_e;

  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } digits_t;

  // Leading-zero blanking: hundreds blanks when it is zero, tens blanks only
  // when both hundreds and tens are zero. The ones position never blanks.
  function automatic logic pos_blank(input digits_t d, input logic [1:0] pos,
                                     input logic lzb_en);
    case (pos)
      2'd1:    return lzb_en && (d.d2 == 4'd0) && (d.d1 == 4'd0);
      2'd2:    return lzb_en && (d.d2 == 4'd0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd  in  4  digit value; 10..15 are shown as a dash
//   seg  out 7  cathode pattern, active-low, {g,f,e,d,c,b,a}
module bcd_to_seg
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Straight lookup; anything outside 0..9 is a dash so a bad upstream
  // value is visible on the display instead of silently looking like a digit.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a 4-digit common-anode display.
// Snapshots three BCD digits on a load strobe and scans them one anode at a
// time, with leading-zero blanking, dead time between digits and optional blink.
// Ports:
//   clk       in   1  system clock
//   reset     in   1  synchronous, active-high reset
//   digit0..2 in   4  BCD ones / tens / hundreds
//   load      in   1  one-cycle strobe capturing digit0..2
//   lzb_en    in   1  blank leading zeros on positions 2 and 1
//   blink_en  in   1  alternate display on/off every BLINK_DIV frames
//   an        out  4  anode enables, active-low, an[0] = rightmost
//   seg       out  7  cathodes, active-low, {g,f,e,d,c,b,a}
//   dp        out  1  decimal point, active-low, always off
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 500,
  parameter int BLINK_DIV   = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic       load,
  input  logic       lzb_en,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_CNT   = CW'(DEAD_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  digits_t        snap_q, snap_d;
  digits_t        disp_q, disp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [FW-1:0]  frame_q, frame_d;
  blink_phase_e   phase_q, phase_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;

  logic           slot_end;
  logic           frame_end;
  logic           lit;
  logic [3:0]     cur_digit;
  logic [6:0]     dec_seg;

  // Digit selected by the current scan index. Slot 3 has no digit of its
  // own; it reuses the hundreds mux leg but its output is forced dark below.
  always_comb begin
    cur_digit = disp_q.d2;
    case (idx_q)
      2'd0:    cur_digit = disp_q.d0;
      2'd1:    cur_digit = disp_q.d1;
      default: cur_digit = disp_q.d2;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Next-state logic. The load strobe lands in snap immediately, but the
  // copy that is actually displayed (disp) only follows at a slot boundary,
  // so a digit never changes while its anode is on.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == 2'd3);

    snap_d  = load ? digits_t'({digit2, digit1, digit0}) : snap_q;
    disp_d  = slot_end ? snap_d : disp_q;
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    idx_d   = slot_end ? idx_q + 2'd1 : idx_q;

    frame_d = frame_q;
    phase_d = phase_q;
    if (!blink_en) begin
      frame_d = '0;
      phase_d = PHASE_ON;
    end else if (frame_end) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // seg carries the slot's pattern even while the anode is held off, so
    // the cathodes have settled before the anode turns on.
    lit = (cnt_q >= DEAD_CNT) && (idx_q != 2'd3) &&
          !pos_blank(disp_q, idx_q, lzb_en) &&
          !(blink_en && (phase_q == PHASE_OFF));

    an_d = AN_OFF;
    if (lit) an_d[idx_q] = 1'b0;
    seg_d = (idx_q == 2'd3) ? SEG_OFF : dec_seg;
  end

  // All state, including the registered outputs, restarts together on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q  <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= PHASE_ON;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      snap_q  <= snap_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan with small refresh/dead/blink parameters.
// A cycle-level behavioural model (time since reset, displayed digits,
// frames since blink was enabled) predicts an/seg/dp every cycle; a few
// directed sequences pin the model with hand-computed literal values.
module tb_seven_seg_scan;

  localparam int R = 4;
  localparam int D = 1;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0;
  logic       load = 1'b0, lzb_en = 1'b0, blink_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;

  seven_seg_scan #(
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D),
    .BLINK_DIV   (B)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .load     (load),
    .lzb_en   (lzb_en),
    .blink_en (blink_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Segment table straight from the digit shapes; 10..15 are a dash.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
  end

  // Model state: cycles since reset, pending and displayed digits, and how
  // many frames have completed while blink has been continuously enabled.
  int         m_t = 0;
  int         m_frames = 0;
  logic [3:0] m_snap [3];
  logic [3:0] m_disp [3];
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  bit         m_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs that the coming edge will register, from where the
  // scan sits in time (slot = t / R, position within slot = t % R).
  always @(posedge clk) begin
    if (reset) begin
      m_t = 0;
      m_frames = 0;
      for (int i = 0; i < 3; i++) begin
        m_snap[i] = 4'd0;
        m_disp[i] = 4'd0;
      end
      exp_an = 4'hF;
      exp_seg = 7'h7F;
      m_valid = 1'b1;
    end else begin
      int  cnt, pos;
      bit  blank, on;
      cnt = m_t % R;
      pos = (m_t / R) % 4;
      blank = (pos == 2 && lzb_en && m_disp[2] == 0) ||
              (pos == 1 && lzb_en && m_disp[2] == 0 && m_disp[1] == 0);
      on = (cnt >= D) && (pos != 3) && !blank &&
           !(blink_en && ((m_frames / B) % 2 == 1));
      exp_seg = (pos == 3) ? 7'h7F : seg_tab[m_disp[pos]];
      exp_an = on ? ~(4'b0001 << pos) : 4'hF;
      if (load) begin
        m_snap[0] = digit0;
        m_snap[1] = digit1;
        m_snap[2] = digit2;
      end
      if (cnt == R - 1) m_disp = m_snap;
      if (!blink_en) m_frames = 0;
      else if (pos == 3 && cnt == R - 1) m_frames++;
      m_t++;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model an", 16'(an), 16'(exp_an));
      checkOutput("model seg", 16'(seg), 16'(exp_seg));
      checkOutput("model dp", 16'(dp), 16'(1'b1));
    end
  end

  // Drive one cycle's worth of inputs and return at the following negedge.
  task automatic applyStimulus(input logic rst, input logic ld,
                               input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic lzb,
                               input logic blk);
    reset = rst; load = ld;
    digit0 = d0; digit1 = d1; digit2 = d2;
    lzb_en = lzb; blink_en = blk;
    @(negedge clk);
  endtask

  int low0, low12, bad_seg;

  initial begin
    repeat (3) applyStimulus(1, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    checkOutput("reset an", 16'(an), 16'(4'b1111));
    checkOutput("reset seg", 16'(seg), 16'(7'b1111111));
    checkOutput("reset dp", 16'(dp), 16'(1'b1));

    // Load 3,2,1 on the first edge; the ones digit first shows in frame 2.
    applyStimulus(0, 1, 4'd1, 4'd2, 4'd3, 0, 0);
    checkOutput("first dead seg", 16'(seg), 16'(7'b1000000));
    checkOutput("first dead an", 16'(an), 16'(4'b1111));
    repeat (16) applyStimulus(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    checkOutput("pos0 dead an", 16'(an), 16'(4'b1111));
    checkOutput("pos0 dead seg", 16'(seg), 16'(7'b1111001));
    applyStimulus(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    checkOutput("pos0 lit an", 16'(an), 16'(4'b1110));
    checkOutput("pos0 lit seg", 16'(seg), 16'(7'b1111001));
    repeat (4) applyStimulus(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    checkOutput("pos1 lit an", 16'(an), 16'(4'b1101));
    checkOutput("pos1 lit seg", 16'(seg), 16'(7'b0100100));
    repeat (8) applyStimulus(0, 0, 4'd1, 4'd2, 4'd3, 0, 0);
    checkOutput("slot3 an", 16'(an), 16'(4'b1111));
    checkOutput("slot3 seg", 16'(seg), 16'(7'b1111111));

    // 7,0,0 with blanking: after one frame to settle, two frames hold
    // exactly six lit cycles on pos0 and none on pos1/pos2.
    applyStimulus(0, 1, 4'd7, 4'd0, 4'd0, 1, 0);
    repeat (15) applyStimulus(0, 0, 4'd7, 4'd0, 4'd0, 1, 0);
    low0 = 0; low12 = 0; bad_seg = 0;
    repeat (32) begin
      applyStimulus(0, 0, 4'd7, 4'd0, 4'd0, 1, 0);
      if (an[2:1] != 2'b11) low12++;
      if (an[0] == 1'b0) begin
        low0++;
        if (seg != 7'b1111000) bad_seg++;
      end
    end
    checkOutput("lzb pos1/pos2 dark", 16'(low12), 16'd0);
    checkOutput("lzb pos0 lit cycles", 16'(low0), 16'd6);
    checkOutput("lzb pos0 pattern", 16'(bad_seg), 16'd0);

    // Randomised run: occasional resets, frequent loads, slow-changing
    // blanking and blink enables so blink periods actually complete.
    begin
      logic [3:0] r0, r1, r2;
      logic       rl, lz, bk, rs;
      lz = 1'b0; bk = 1'b0;
      r0 = 4'd0; r1 = 4'd0; r2 = 4'd0;
      for (int c = 0; c < 4000; c++) begin
        rs = ($urandom_range(0, 299) == 0);
        rl = ($urandom_range(0, 5) == 0);
        if (rl) begin
          r0 = 4'($urandom_range(0, 15));
          r1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          r2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 59) == 0) lz = ~lz;
        if ($urandom_range(0, 399) == 0) bk = ~bk;
        applyStimulus(rs, rl, r0, r1, r2, lz, bk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
